// File: rtl/mcg_pkg.sv
// Shared types, default widths and the saturating helper for multi_carrier_generator.
// DEF_* and LOG2_NC/INT_W describe the default build; the top derives its own widths the same way.
package mcg_pkg;

  typedef enum logic {
    MODE_LS = 1'b0,
    MODE_PS = 1'b1
  } mode_e;

  localparam int DEF_NUM_CARRIERS  = 4;
  localparam int DEF_CARRIER_WIDTH = 16;
  localparam int DEF_COUNTER_WIDTH = 16;

  localparam int LOG2_NC = $clog2(DEF_NUM_CARRIERS);
  localparam int INT_W   = DEF_CARRIER_WIDTH + LOG2_NC + 1;

  // Clamp a signed value to the signed range of a w-bit word (w is a constant at every call site).
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/mcg_tri_fold.sv
// Folds a phase in [0, 2P) onto the base triangle: tri = ph for ph <= P, else 2P - ph.
module mcg_tri_fold #(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic [COUNTER_WIDTH:0]   i_phase,
  input  logic [COUNTER_WIDTH-1:0] i_period,
  output logic [COUNTER_WIDTH-1:0] o_tri
);

  logic [COUNTER_WIDTH:0] w_p_ext;

  assign w_p_ext = {1'b0, i_period};
  assign o_tri   = (i_phase <= w_p_ext) ? COUNTER_WIDTH'(i_phase)
                                        : COUNTER_WIDTH'((w_p_ext << 1) - i_phase);

endmodule

// File: rtl/multi_carrier_generator.sv
// NUM_CARRIERS triangular carriers (level- or phase-shifted) with valley-synchronous shadow registers.
// Define CARRIER_ADC_TRIG_EN to add the trig_point input and the adc_trig pulse output.
module multi_carrier_generator
  import mcg_pkg::*;
#(
  parameter int NUM_CARRIERS  = DEF_NUM_CARRIERS,
  parameter int CARRIER_WIDTH = DEF_CARRIER_WIDTH,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  enable,
  input  logic                                  mode,
  input  logic [COUNTER_WIDTH-1:0]              freq_div,
  input  logic [COUNTER_WIDTH-1:0]              period,
`ifdef CARRIER_ADC_TRIG_EN
  input  logic [COUNTER_WIDTH-1:0]              trig_point,
  output logic                                  adc_trig,
`endif
  output logic [NUM_CARRIERS*CARRIER_WIDTH-1:0] carriers,
  output logic                                  sync_valley,
  output logic                                  sync_peak,
  output logic                                  shadow_loaded
);

  localparam int LOG2_N = $clog2(NUM_CARRIERS);
  localparam int CALC_W = CARRIER_WIDTH + LOG2_N + 1;
  localparam int PH_W   = COUNTER_WIDTH + 1;

  logic [COUNTER_WIDTH-1:0] r_div_cnt;
  logic [COUNTER_WIDTH-1:0] r_fd_sh;
  logic [COUNTER_WIDTH-1:0] r_per_sh;
  mode_e                    r_mode_sh;
  logic [PH_W-1:0]          r_step_sh;
  logic [PH_W-1:0]          r_phase;
  logic                     r_adv;
  logic [NUM_CARRIERS*CARRIER_WIDTH-1:0] r_carriers;
  logic                     r_valley;
  logic                     r_peak;
  logic                     r_loaded;

  logic [COUNTER_WIDTH-1:0] w_p_eff;
  logic [COUNTER_WIDTH-1:0] w_in_p_eff;
  logic [PH_W-1:0]          w_two_p;
  logic [PH_W-1:0]          w_in_step;
  logic [PH_W-1:0]          w_ph_now;
  logic                     w_tick;
  logic                     w_wrap;
  logic                     w_load;
  logic signed [CALC_W-1:0] w_p_s;
  logic signed [CALC_W-1:0] w_tri0_s;
  logic [COUNTER_WIDTH-1:0] w_tri [NUM_CARRIERS];
  logic [NUM_CARRIERS*CARRIER_WIDTH-1:0] w_car_bus;

  // A programmed period of 0 behaves as 1 so the triangle never degenerates.
  assign w_p_eff    = (r_per_sh == '0) ? COUNTER_WIDTH'(1) : r_per_sh;
  assign w_in_p_eff = (period == '0) ? COUNTER_WIDTH'(1) : period;
  assign w_two_p    = {w_p_eff, 1'b0};
  assign w_in_step  = {w_in_p_eff, 1'b0} >> LOG2_N;
  assign w_ph_now   = enable ? r_phase : '0;
  assign w_tick     = (r_div_cnt == r_fd_sh);
  assign w_wrap     = w_tick && (r_phase == w_two_p - PH_W'(1));
  assign w_load     = !enable || w_wrap;
  assign w_p_s      = signed'(CALC_W'(w_p_eff));
  assign w_tri0_s   = signed'(CALC_W'(w_tri[0]));

  for (genvar k = 0; k < NUM_CARRIERS; k++) begin : g_car
    logic [PH_W:0]            w_sum;
    logic [PH_W-1:0]          w_ph_k;
    logic signed [CALC_W-1:0] w_ls;
    logic signed [CALC_W-1:0] w_ps;
    logic signed [CALC_W-1:0] w_val;

    // ph + k*STEP stays below 4P, so one conditional subtract completes the modulo.
    assign w_sum  = (PH_W+1)'(w_ph_now) + (PH_W+1)'(k) * (PH_W+1)'(r_step_sh);
    assign w_ph_k = (w_sum >= (PH_W+1)'(w_two_p)) ? PH_W'(w_sum - (PH_W+1)'(w_two_p))
                                                  : PH_W'(w_sum);

    mcg_tri_fold #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_fold (
      .i_phase  (w_ph_k),
      .i_period (w_p_eff),
      .o_tri    (w_tri[k])
    );

    assign w_ls  = w_tri0_s + CALC_W'(k) * w_p_s - CALC_W'(NUM_CARRIERS / 2) * w_p_s;
    assign w_ps  = signed'(CALC_W'(w_tri[k])) - (w_p_s >>> 1);
    assign w_val = (r_mode_sh == MODE_PS) ? w_ps : w_ls;
    assign w_car_bus[k*CARRIER_WIDTH +: CARRIER_WIDTH] =
      CARRIER_WIDTH'(saturate(64'(w_val), CARRIER_WIDTH));
  end

  // NOTE: every register here is updated with <= so all of them see pre-edge values of each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt  <= '0;
      r_fd_sh    <= '0;
      r_per_sh   <= '0;
      r_mode_sh  <= MODE_LS;
      r_step_sh  <= '0;
      r_phase    <= '0;
      r_adv      <= 1'b0;
      r_carriers <= '0;
      r_valley   <= 1'b0;
      r_peak     <= 1'b0;
      r_loaded   <= 1'b0;
    end else begin
      r_carriers <= w_car_bus;
      if (w_load) begin
        r_fd_sh   <= freq_div;
        r_per_sh  <= period;
        r_mode_sh <= mode_e'(mode);
        r_step_sh <= w_in_step;
      end
      if (!enable) begin
        r_div_cnt <= '0;
        r_phase   <= '0;
        r_adv     <= 1'b0;
        r_valley  <= 1'b0;
        r_peak    <= 1'b0;
        r_loaded  <= 1'b0;
      end else begin
        // r_adv marks a fresh phase value, so pulses stay one clock wide at any divider.
        r_valley <= r_adv && (r_phase == '0);
        r_peak   <= r_adv && (r_phase == {1'b0, w_p_eff});
        r_adv    <= w_tick;
        r_loaded <= w_wrap;
        if (w_tick) begin
          r_div_cnt <= '0;
          r_phase   <= w_wrap ? '0 : r_phase + PH_W'(1);
        end else begin
          r_div_cnt <= r_div_cnt + COUNTER_WIDTH'(1);
        end
      end
    end
  end

`ifdef CARRIER_ADC_TRIG_EN
  logic [COUNTER_WIDTH-1:0] r_trig_sh;
  logic                     r_adc_trig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_sh  <= '0;
      r_adc_trig <= 1'b0;
    end else begin
      if (w_load) r_trig_sh <= trig_point;
      r_adc_trig <= enable && r_adv && (r_phase == {1'b0, r_trig_sh});
    end
  end

  assign adc_trig = r_adc_trig;
`else
  // Base build: no trigger comparator.
`endif

  assign carriers      = r_carriers;
  assign sync_valley   = r_valley;
  assign sync_peak     = r_peak;
  assign shadow_loaded = r_loaded;

endmodule

// File: doc/multi_carrier_generator.md
Name: multi_carrier_generator

Overview:
Parametrised successor to the two-carrier triangular generator. It produces NUM_CARRIERS signed triangular carriers with a programmable period, in either level-shifted (LS-PWM) or phase-shifted (PS-PWM) mode. Period, divider and mode are written through shadow registers that load only at the carrier valley, so outputs stay glitch-free. It feeds the multilevel PWM comparators in the cascaded H-bridge peripheral.

Parameters:
- NUM_CARRIERS, 4, number of carriers; power of two, 2..8
- CARRIER_WIDTH, 16, width of each signed carrier output
- COUNTER_WIDTH, 16, width of freq_div and period

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run; low holds the block in idle
- mode  in  1  0 = level-shifted, 1 = phase-shifted
- freq_div  in  COUNTER_WIDTH  tick every freq_div+1 clocks
- period  in  COUNTER_WIDTH  triangle peak P; 0 is treated as 1
- carriers  out  NUM_CARRIERS*CARRIER_WIDTH  signed carriers; carrier k occupies bits [k*W +: W]
- sync_valley  out  1  one-clock pulse when phase reaches 0
- sync_peak  out  1  one-clock pulse when phase reaches P
- shadow_loaded  out  1  one-clock pulse when the shadow registers update

Behaviour:
- Reset: all counters, shadow registers and outputs are 0; carriers are all 0.
- Idle (enable=0): div_cnt=0 and phase=0. Shadow registers track the inputs every clock. Carriers are driven with their phase-0 values. Pulses stay 0.
- Tick: div_cnt counts 0..freq_div_sh; tick is asserted when div_cnt==freq_div_sh, and div_cnt then wraps to 0. With freq_div=0 there is a tick every clock.
- Phase: COUNTER_WIDTH+1 bits. On each tick it advances and wraps 2P-1 -> 0. Base triangle: tri(ph) = ph if ph<=P, else 2P-ph.
- Shadow load: on the tick where phase wraps to 0, freq_div_sh, period_sh and mode_sh load from the inputs, and shadow_loaded pulses on that same registered cycle. Input changes made mid-cycle never alter the current triangle.
- LS mode: carrier_k = tri(ph) + k*P - (NUM_CARRIERS/2)*P.
- PS mode:
  - phase_k = (ph + k*STEP) mod 2P, where STEP = (2P) >> log2(NUM_CARRIERS).
  - STEP is computed at shadow load.
  - carrier_k = tri(phase_k) - (P>>1).
- Arithmetic:
  - Compute in CARRIER_WIDTH+log2(NUM_CARRIERS)+1 bits, then saturate to the signed CARRIER_WIDTH range.
  - Software keeps NUM_CARRIERS*P <= 2^(CARRIER_WIDTH-1) in LS mode to avoid saturation.
- Latency: carriers, sync_valley and sync_peak are registered. Each reflects the tick one clock after its phase update. A pulse lasts one clk even when freq_div>0.
- Enable fall mid-cycle: the block returns to idle on the next clock; no pulses are emitted.
- Enable rise: the first tick advances phase to 1. The pre-run shadow values are used.
- rst_n assertion mid-operation: everything clears immediately and asynchronously.

Optional Feature:
- Macro: CARRIER_ADC_TRIG_EN.
- When defined, the block adds input trig_point [COUNTER_WIDTH] and output adc_trig [1].
  - trig_point is shadowed with the other shadow registers.
  - adc_trig pulses one clk, registered, when the tick makes phase == trig_point_sh.
  - trig_point >= 2P never fires.
- When undefined, neither port exists and there is no extra logic.

Decomposition:
- Shared package mcg_pkg holds:
  - the MODE_LS and MODE_PS constants
  - the derived widths LOG2_NC and INT_W
  - the saturate function
- One sub-module, mcg_tri_fold: maps phase and P to tri(). It is instantiated once per carrier for PS mode; LS mode uses instance 0 only.

Test Plan:
- LS, N=4, W=16, P=4, freq_div=0 -> carrier0 runs -8,-7,-6,-5,-4,-5..-8 and carrier3 runs 4..8..4. Triangle period is 8 clocks. sync_peak and sync_valley are each 1 clk, 4 clocks apart.
- PS, N=4, P=8, freq_div=0 -> STEP=4. At phase 0: carrier0=-4, carrier1=0, carrier2=4, carrier3=0 (descending). sync_peak occurs at phase 8.
- Write period 4->6 at phase 2 -> the old triangle completes to phase 7. shadow_loaded pulses at the wrap. The next peak is at 6.
- freq_div=2, P=2 -> phase advances every 3 clocks. A full triangle takes 12 clocks. Pulses stay 1 clk wide.
- Drop enable at phase 3, then restore -> phase returns to 0 with no pulses while idle. On restart, the first tick gives phase 1. Assert rst_n=0 mid-run -> all outputs 0 asynchronously.
- With CARRIER_ADC_TRIG_EN, P=4, trig_point=4 -> adc_trig coincides with sync_peak. With trig_point=9 -> adc_trig never fires.
